int_dec: RTL and testbench



---
 rtl/int_dec.sv | 135 +++++++++++++
 tb/tb_int_dec.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/int_dec.sv
// Cascaded integrator with decimation counter.
// ORDER integrator stages run on sign-extended input samples. One result is emitted every
// DECIM enabled samples. Arithmetic either wraps or clamps to the W-bit signed range.
// Accumulators either run freely (CIC-style) or are dumped to zero at each output.
module int_dec #(
  parameter int unsigned I_WIDTH = 8,
  parameter int unsigned EXTEND  = 4,
  parameter int unsigned ORDER   = 1,
  parameter int unsigned DECIM   = 4,
  parameter bit          DUMP    = 1'b0,
  parameter bit          SAT     = 1'b0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_clr,
  input  logic [I_WIDTH-1:0]           i_x,
  output logic [I_WIDTH+EXTEND-1:0]    o_y,
  output logic                         o_valid,
  output logic                         o_ovf
);

  localparam int unsigned W  = I_WIDTH + EXTEND;
  localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [W-1:0]  MaxVal  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MinVal  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CntLast = CW'(DECIM - 1);

  // State
  logic [W-1:0]  acc_q [ORDER];
  logic [W-1:0]  acc_d [ORDER];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  // Datapath
  logic [W-1:0]     x_ext;
  logic [W-1:0]     src [ORDER];
  logic [W:0]       sum [ORDER];
  logic [W-1:0]     res [ORDER];
  logic [ORDER-1:0] stage_ovf;
  logic             any_ovf;
  logic             last;

  assign x_ext   = {{EXTEND{i_x[I_WIDTH-1]}}, i_x};
  assign any_ovf = |stage_ovf;
  assign last    = (cnt_q == CntLast);

  // Stage operand selection: stage 0 takes the input, stage k takes stage k-1's pre-edge value.
  always_comb begin
    src[0] = x_ext;
    for (int unsigned k = 1; k < ORDER; k++) begin
      src[k] = acc_q[k-1];
    end
  end

  // Per-stage W+1 bit sum, overflow detect, and wrap/clamp.
  always_comb begin
    for (int unsigned k = 0; k < ORDER; k++) begin
      sum[k]       = {acc_q[k][W-1], acc_q[k]} + {src[k][W-1], src[k]};
      // Overflow when the two top bits of the wide sum disagree.
      stage_ovf[k] = sum[k][W] ^ sum[k][W-1];
      if (SAT && stage_ovf[k]) begin
        res[k] = sum[k][W] ? MinVal : MaxVal;
      end else begin
        res[k] = sum[k][W-1:0];
      end
    end
  end

  // Next-state: clear has priority, otherwise advance only on enabled samples.
  always_comb begin
    for (int unsigned k = 0; k < ORDER; k++) begin
      acc_d[k] = acc_q[k];
    end
    cnt_d   = cnt_q;
    y_d     = y_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;

    if (i_clr) begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        acc_d[k] = '0;
      end
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (i_en) begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        acc_d[k] = res[k];
      end
      ovf_d = ovf_q | any_ovf;
      if (last) begin
        cnt_d   = '0;
        y_d     = res[ORDER-1];
        valid_d = 1'b1;
        // Dump mode: the emitted value includes this sample, the next window starts at zero.
        if (DUMP) begin
          for (int unsigned k = 0; k < ORDER; k++) begin
            acc_d[k] = '0;
          end
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        acc_q[k] <= '0;
      end
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        acc_q[k] <= acc_d[k];
      end
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_y     = y_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_int_dec.sv
// Directed bench for int_dec: five instances in different configurations share one stimulus.
module tb_int_dec;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] x;

  logic [11:0] ya, yb, yc, ys, yw;
  logic        va, vb, vc, vs, vw;
  logic        oa, ob, oc, os, ow;

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: order 1, decim 4, dump
  int_dec #(.I_WIDTH(8), .EXTEND(4), .ORDER(1), .DECIM(4), .DUMP(1'b1), .SAT(1'b0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_x(x),
    .o_y(ya), .o_valid(va), .o_ovf(oa)
  );
  // B: order 1, decim 4, free-running
  int_dec #(.I_WIDTH(8), .EXTEND(4), .ORDER(1), .DECIM(4), .DUMP(1'b0), .SAT(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_x(x),
    .o_y(yb), .o_valid(vb), .o_ovf(ob)
  );
  // C: order 2, decim 1
  int_dec #(.I_WIDTH(8), .EXTEND(4), .ORDER(2), .DECIM(1), .DUMP(1'b0), .SAT(1'b0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_x(x),
    .o_y(yc), .o_valid(vc), .o_ovf(oc)
  );
  // S: order 1, decim 1, saturating
  int_dec #(.I_WIDTH(8), .EXTEND(4), .ORDER(1), .DECIM(1), .DUMP(1'b0), .SAT(1'b1)) u_s (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_x(x),
    .o_y(ys), .o_valid(vs), .o_ovf(os)
  );
  // W: order 1, decim 1, wrapping
  int_dec #(.I_WIDTH(8), .EXTEND(4), .ORDER(1), .DECIM(1), .DUMP(1'b0), .SAT(1'b0)) u_w (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_x(x),
    .o_y(yw), .o_valid(vw), .o_ovf(ow)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    x     = 8'd0;
    tick();
    tick();
    chk("rst_y", int'($signed(ya)), 0);
    chk("rst_valid", int'(va), 0);
    chk("rst_ovf", int'(oa), 0);
    chk("rst_acc", int'($signed(u_a.acc_q[0])), 0);
    rst = 1'b0;

    // Tests 1 and 2: x=3 held for four windows
    x  = 8'd3;
    en = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("t1_valid", int'(va), int'(c == 3));
        chk("t2_valid", int'(vb), int'(c == 3));
      end
      chk("t1_y", int'($signed(ya)), 12);
      chk("t1_acc_dumped", int'($signed(u_a.acc_q[0])), 0);
      chk("t2_y", int'($signed(yb)), 12 * (w + 1));
    end
    x = 8'h80;  // -128
    for (int c = 0; c < 4; c++) tick();
    chk("t2_neg_valid", int'(vb), 1);
    chk("t2_neg_y", int'($signed(yb)), -464);
    chk("t1_neg_y", int'($signed(ya)), -512);

    // Test 3: second-order integrator, decim 1
    do_reset();
    x  = 8'd1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_valid", int'(vc), 1);
      chk("t3_y", int'($signed(yc)), (i * (i + 1)) / 2);
    end

    // Test 4: saturate vs wrap with x=127
    do_reset();
    x  = 8'd127;
    en = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("t4_sat_y16", int'($signed(ys)), 2032);
    chk("t4_sat_ovf16", int'(os), 0);
    tick();
    chk("t4_sat_y17", int'($signed(ys)), 2047);
    chk("t4_sat_ovf17", int'(os), 1);
    chk("t4_wrap_y17", int'($signed(yw)), -1937);
    chk("t4_wrap_ovf17", int'(ow), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr_ovf_s", int'(os), 0);
    chk("t4_clr_ovf_w", int'(ow), 0);
    chk("t4_clr_hold_s", int'($signed(ys)), 2047);
    chk("t4_clr_hold_w", int'($signed(yw)), -1937);
    chk("t4_clr_valid", int'(vs), 0);

    // Test 5: enable gaps, then clear mid-window
    do_reset();
    x = 8'd5;
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      tick();
      chk("t5_valid", int'(va), int'(i == 6 || i == 14));
      if (i == 6 || i == 14) chk("t5_y", int'($signed(ya)), 20);
    end
    en = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_valid", int'(va), 0);
    chk("t5_clr_acc", int'($signed(u_a.acc_q[0])), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_post_clr_valid", int'(va), int'(i == 3));
    end
    chk("t5_post_clr_y", int'($signed(ya)), 20);

    // Test 6: asynchronous reset mid-window
    x = 8'd2;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_y_a", int'($signed(ya)), 0);
    chk("t6_async_y_w", int'($signed(yw)), 0);
    chk("t6_async_valid_w", int'(vw), 0);
    chk("t6_async_acc", int'($signed(u_a.acc_q[0])), 0);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_valid", int'(va), int'(i == 3));
    end
    chk("t6_y", int'($signed(ya)), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
